// File: rtl/tdma_slot_arbiter.sv
// rtl/tdma_slot_arbiter.sv - TDMA slot-owner arbiter; define TDMA_ARB_RECLAIM_EN to hand missed slots to other requesters
module tdma_slot_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int REQ_IDX_W  = 2,
  parameter int NUM_SLOTS  = 8,
  parameter int SLOT_IDX_W = 3
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  enable,
  input  logic                  slot_start,
  input  logic                  tbl_we,
  input  logic [SLOT_IDX_W-1:0] tbl_addr,
  input  logic [REQ_IDX_W:0]    tbl_wdata,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    grant,
  output logic [SLOT_IDX_W-1:0] cur_slot,
  output logic                  slot_missed,
  input  logic                  cnt_clr,
  output logic [15:0]           missed_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ARB  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [SLOT_IDX_W-1:0] LAST_SLOT = SLOT_IDX_W'(NUM_SLOTS - 1);

  logic [1:0]            state;
  logic [REQ_IDX_W:0]    tbl [NUM_SLOTS];
  logic [15:0]           miss_cnt;
  logic [SLOT_IDX_W-1:0] next_slot;
  logic [REQ_IDX_W:0]    entry;
  logic [REQ_IDX_W-1:0]  owner;
  logic                  owner_hit;
  logic [NUM_REQ-1:0]    owner_onehot;
  logic [NUM_REQ-1:0]    reclaim_grant;
  logic                  reclaim_any;

  assign missed_count = miss_cnt;
  assign next_slot    = (cur_slot == LAST_SLOT) ? '0 : cur_slot + 1'b1;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        tbl[i] <= '0;
      end
    end else if (tbl_we && (32'(tbl_addr) < NUM_SLOTS)) begin
      tbl[tbl_addr] <= tbl_wdata;
    end
  end

  // Out-of-range owner indices behave exactly like an invalid entry.
  always_comb begin
    entry        = tbl[cur_slot];
    owner        = entry[REQ_IDX_W-1:0];
    owner_onehot = '0;
    owner_hit    = 1'b0;
    if (entry[REQ_IDX_W] && (32'(owner) < NUM_REQ)) begin
      owner_onehot[owner] = 1'b1;
      owner_hit           = req[owner];
    end
  end

`ifdef TDMA_ARB_RECLAIM_EN
  logic [REQ_IDX_W-1:0] rr_ptr;
  logic [REQ_IDX_W-1:0] pick;

  // Descending scan so the requester closest to rr_ptr is the last writer.
  always_comb begin
    pick          = '0;
    reclaim_grant = '0;
    reclaim_any   = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(32'(rr_ptr) + k) % NUM_REQ]) begin
        pick = REQ_IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
      end
    end
    reclaim_grant[pick] = reclaim_any;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rr_ptr <= '0;
    end else if (enable && (state == ST_ARB) && !owner_hit && reclaim_any) begin
      rr_ptr <= REQ_IDX_W'((32'(pick) + 1) % NUM_REQ);
    end
  end
`else
  assign reclaim_grant = '0;
  assign reclaim_any   = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state       <= ST_IDLE;
      grant       <= '0;
      cur_slot    <= LAST_SLOT;
      slot_missed <= 1'b0;
    end else begin
      slot_missed <= 1'b0;
      if (!enable) begin
        state <= ST_IDLE;
        grant <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            grant    <= '0;
            cur_slot <= LAST_SLOT;
            state    <= ST_WAIT;
          end
          ST_WAIT: begin
            if (slot_start) begin
              cur_slot <= next_slot;
              state    <= ST_ARB;
            end
          end
          ST_ARB: begin
            if (owner_hit) begin
              grant <= owner_onehot;
              state <= ST_HOLD;
            end else begin
              slot_missed <= 1'b1;
              if (reclaim_any) begin
                grant <= reclaim_grant;
                state <= ST_HOLD;
              end else begin
                state <= ST_WAIT;
              end
            end
          end
          ST_HOLD: begin
            // A slot boundary outranks a simultaneous request drop.
            if (slot_start) begin
              grant    <= '0;
              cur_slot <= next_slot;
              state    <= ST_ARB;
            end else if ((grant & req) == '0) begin
              grant <= '0;
              state <= ST_WAIT;
            end
          end
          default: begin
            grant <= '0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN || cnt_clr) begin
      miss_cnt <= '0;
    end else if (slot_missed && (miss_cnt != 16'hFFFF)) begin
      miss_cnt <= miss_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_tdma_slot_arbiter.sv
// tb/tb_tdma_slot_arbiter.sv - scoreboard bench for tdma_slot_arbiter with a slot-level reference model
module tb_tdma_slot_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int REQ_IDX_W  = 2;
  localparam int NUM_SLOTS  = 8;
  localparam int SLOT_IDX_W = 3;

  typedef struct packed {
    logic [NUM_REQ-1:0]    g;
    logic                  m;
    logic [SLOT_IDX_W-1:0] s;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  ARESETN;
  logic                  enable;
  logic                  slot_start;
  logic                  tbl_we;
  logic [SLOT_IDX_W-1:0] tbl_addr;
  logic [REQ_IDX_W:0]    tbl_wdata;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    grant;
  logic [SLOT_IDX_W-1:0] cur_slot;
  logic                  slot_missed;
  logic                  cnt_clr;
  logic [15:0]           missed_count;

  int checks = 0;
  int errors = 0;

  exp_t               exp_q[$];
  logic [REQ_IDX_W:0] m_tbl [NUM_SLOTS];
  int                 m_slot;
  int                 m_rr;
  int                 m_cnt;

  tdma_slot_arbiter #(
    .NUM_REQ(NUM_REQ), .REQ_IDX_W(REQ_IDX_W),
    .NUM_SLOTS(NUM_SLOTS), .SLOT_IDX_W(SLOT_IDX_W)
  ) dut (
    .ACLK(clk), .ARESETN(ARESETN), .enable(enable), .slot_start(slot_start),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .req(req),
    .grant(grant), .cur_slot(cur_slot), .slot_missed(slot_missed),
    .cnt_clr(cnt_clr), .missed_count(missed_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_SLOTS; i++) m_tbl[i] = '0;
    m_slot = NUM_SLOTS - 1;
    m_rr   = 0;
    m_cnt  = 0;
    exp_q.delete();
  endtask

  task automatic monitor();
    logic [NUM_REQ-1:0] prev_g;
    exp_t e;
    prev_g = '0;
    forever begin
      @(posedge clk);
      #1;
      if (ARESETN === 1'b1) begin
        chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        if (slot_missed || (grant != '0 && prev_g == '0)) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual grant=%b missed=%b required no slot outcome", grant, slot_missed);
          end else begin
            e = exp_q.pop_front();
            chk("result_grant", 32'(grant), 32'(e.g));
            chk("result_missed", 32'(slot_missed), 32'(e.m));
            chk("result_slot", 32'(cur_slot), 32'(e.s));
          end
        end
      end
      prev_g = grant;
    end
  endtask

  task automatic wr(input int a, input logic [REQ_IDX_W:0] d);
    tbl_we    = 1'b1;
    tbl_addr  = SLOT_IDX_W'(a);
    tbl_wdata = d;
    @(negedge clk);
    tbl_we = 1'b0;
    m_tbl[a] = d;
  endtask

  // One complete slot: boundary pulse, arbitration outcome, counter settle.
  task automatic do_slot(input logic [NUM_REQ-1:0] r, input bit late_wr,
                         input logic [REQ_IDX_W:0] late_data, input bit clr);
    exp_t               e;
    logic [REQ_IDX_W:0] ent;
    logic [NUM_REQ-1:0] prev_g;
    int                 own;
    prev_g = grant;
    req    = r;
    m_slot = (m_slot + 1) % NUM_SLOTS;
    ent    = m_tbl[m_slot];
    own    = int'(ent[REQ_IDX_W-1:0]);
    e.s    = SLOT_IDX_W'(m_slot);
    e.g    = '0;
    e.m    = 1'b0;
    if (ent[REQ_IDX_W] && own < NUM_REQ && r[own]) begin
      e.g = NUM_REQ'(1) << own;
    end else begin
      e.m = 1'b1;
`ifdef TDMA_ARB_RECLAIM_EN
      for (int k = 0; k < NUM_REQ; k++) begin
        if (e.g == '0 && r[(m_rr + k) % NUM_REQ]) begin
          e.g  = NUM_REQ'(1) << ((m_rr + k) % NUM_REQ);
          m_rr = ((m_rr + k) % NUM_REQ + 1) % NUM_REQ;
        end
      end
`endif
    end
    exp_q.push_back(e);
    slot_start = 1'b1;
    @(negedge clk);
    slot_start = 1'b0;
    chk("cur_slot", 32'(cur_slot), 32'(m_slot));
    if (prev_g != '0) chk("guard_cycle", 32'(grant), 32'd0);
    if (late_wr) begin
      tbl_we    = 1'b1;
      tbl_addr  = SLOT_IDX_W'(m_slot);
      tbl_wdata = late_data;
    end
    @(negedge clk);
    tbl_we = 1'b0;
    if (late_wr) m_tbl[m_slot] = late_data;
    cnt_clr = clr;
    @(negedge clk);
    cnt_clr = 1'b0;
    if (clr) m_cnt = 0;
    else if (e.m && m_cnt < 65535) m_cnt++;
    chk("missed_count", 32'(missed_count), 32'(m_cnt));
    chk("result_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    ARESETN = 1'b0; enable = 1'b0; slot_start = 1'b0; tbl_we = 1'b0;
    tbl_addr = '0; tbl_wdata = '0; req = '0; cnt_clr = 1'b0;
    model_reset();
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_cur_slot", 32'(cur_slot), NUM_SLOTS - 1);
    chk("rst_slot_missed", 32'(slot_missed), 32'd0);
    chk("rst_missed_count", 32'(missed_count), 32'd0);
    ARESETN = 1'b1;
    @(negedge clk);

    wr(0, 3'b101);
    wr(1, 3'b110);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    do_slot(4'b0110, 1'b0, '0, 1'b0);
    do_slot(4'b0110, 1'b0, '0, 1'b0);

    req = 4'b0010;
    @(negedge clk);
    chk("early_release", 32'(grant), 32'd0);
    req = 4'b0110;
    repeat (2) @(negedge clk);
    chk("no_regrant", 32'(grant), 32'd0);

    do_slot(4'b1111, 1'b0, '0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(1, 0) == 1) wr(int'($urandom_range(NUM_SLOTS - 1, 0)), 3'($urandom));
      do_slot(4'($urandom), $urandom_range(3, 0) == 0, 3'($urandom), 1'b0);
    end

    for (int s = 0; s < NUM_SLOTS; s++) wr(s, 3'b100);
    do_slot(4'b0001, 1'b0, '0, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_grant", 32'(grant), 32'd0);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    m_slot = NUM_SLOTS - 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NUM_SLOTS + 1; i++) do_slot(4'b0001, 1'b0, '0, 1'b0);

    do_slot(4'b0001, 1'b0, '0, 1'b0);
    ARESETN = 1'b0;
    @(negedge clk);
    chk("rst_hold_grant", 32'(grant), 32'd0);
    chk("rst_hold_count", 32'(missed_count), 32'd0);
    chk("rst_hold_slot", 32'(cur_slot), NUM_SLOTS - 1);
    ARESETN = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < NUM_SLOTS; i++) do_slot(4'($urandom), 1'b0, '0, 1'b0);

    force dut.miss_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.miss_cnt;
    m_cnt = 65534;
    @(negedge clk);
    chk("preload_count", 32'(missed_count), 32'hFFFE);
    do_slot(4'b1111, 1'b0, '0, 1'b0);
    do_slot(4'b1111, 1'b0, '0, 1'b0);
    do_slot(4'b1111, 1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdma_slot_arbiter.md
# tdma_slot_arbiter

Sequences access to a shared TDMA transmit resource. It follows the slot boundaries produced by the TDMA slot generator and grants exactly one requester per slot, using a programmable slot-owner table. The block sits between the slot generator's slot pulse and the requester datapaths. Its table write port is driven by the AXI-lite register bank.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- REQ_IDX_W, 2, width of a requester index (clog2(NUM_REQ)).
- NUM_SLOTS, 8, slots per TDMA frame (2..16).
- SLOT_IDX_W, 3, width of a slot index (clog2(NUM_SLOTS)).

Ports:
- ACLK  in  1  clock; one clock domain, all logic on the rising edge.
- ARESETN  in  1  reset; synchronous, active-low.
- enable  in  1  arbiter run enable.
- slot_start  in  1  one-cycle pulse from the slot generator marking a slot boundary.
- tbl_we  in  1  slot-owner table write strobe.
- tbl_addr  in  SLOT_IDX_W  table entry index.
- tbl_wdata  in  REQ_IDX_W+1  bit [REQ_IDX_W] = entry valid; low bits = owner index.
- req  in  NUM_REQ  level request per requester.
- grant  out  NUM_REQ  registered one-hot grant (or zero).
- cur_slot  out  SLOT_IDX_W  index of the current slot.
- slot_missed  out  1  one-cycle pulse: the owner was not requesting, or the entry was invalid.
- cnt_clr  in  1  clears missed_count.
- missed_count  out  16  saturating count of slot_missed pulses.

## Operation
- Reset values:
  - state = IDLE; grant = 0; cur_slot = NUM_SLOTS-1; slot_missed = 0; missed_count = 0; rr_ptr = 0.
  - All table entries are invalid.
- Table:
  - Register array of NUM_SLOTS entries, written whenever tbl_we is high, in any state.
  - ARB reads the entry as registered before the edge. A write to the entry being arbitrated in that same cycle takes effect in the next frame.
- cur_slot:
  - On each slot_start sampled while enable = 1, cur_slot increments and wraps from NUM_SLOTS-1 to 0.
  - Leaving IDLE resets the sequence, so the first slot_start after entering RUN selects slot 0.
- States:
  - IDLE: grant = 0. When enable = 1, go to WAIT with cur_slot = NUM_SLOTS-1.
  - WAIT: grant = 0. On slot_start, advance cur_slot and go to ARB.
  - ARB (one cycle):
    - If the entry is valid and req[owner] = 1: grant = onehot(owner), go to HOLD.
    - Otherwise: pulse slot_missed and apply the reclaim rule (see Configuration); if nothing is granted, go to WAIT.
  - HOLD: grant is held.
    - If req of the granted requester drops, grant clears on the next edge and the state goes to WAIT; there is no re-grant within the same slot.
    - If slot_start arrives, grant clears on that edge, cur_slot advances, and the state goes to ARB.
- Priority and boundary rules:
  - enable = 0 in any state: grant clears on the next edge and the state goes to IDLE. This has priority over slot_start.
  - slot_start during ARB: ignored. The slot generator guarantees slots are at least 4 cycles long.
  - missed_count: +1 on each slot_missed, saturating at 0xFFFF. When cnt_clr and an increment occur in the same cycle, the result is 0 (cnt_clr wins).
  - An owner index >= NUM_REQ in a valid entry is treated as an invalid entry.

## Timing
- slot_start high in cycle c → cur_slot updated in c+1 (state ARB) → grant and/or slot_missed visible in c+2.
- Grant release: grant is low in the cycle after req drops, or in the cycle after slot_start is sampled. This leaves at least one cycle of guard between consecutive owners.
- slot_missed is high for exactly one cycle, c+2. missed_count reflects that pulse in c+3.
- grant is never multi-hot and never changes except on the edges defined above.

## Configuration
- TDMA_ARB_RECLAIM_EN defined:
  - On a miss in ARB, grant the first requesting index other than the owner, searching round-robin from rr_ptr.
  - Set rr_ptr to the granted index + 1, mod NUM_REQ.
  - Go to HOLD; slot_missed still pulses.
  - If no requester is active, go to WAIT.
- TDMA_ARB_RECLAIM_EN undefined: a missed slot stays idle. rr_ptr logic is not built.

## Test plan
- Basic grant:
  - Stimulus: table slot0 = owner 1 valid, slot1 = owner 2 valid; enable = 1; req = 4'b0110; slot_start in cycle 10.
  - Required: cur_slot = 0 in cycle 11; grant = 4'b0010 in cycle 12.
  - Next slot_start: grant = 0 for one cycle, then grant = 4'b0100.
- Early release:
  - Stimulus: the owner drops req mid-slot.
  - Required: grant = 0 in the next cycle and stays 0 until the next slot boundary.
- Miss without reclaim:
  - Stimulus: slot2 entry invalid, req = 4'b1111.
  - Required: slot_missed pulses in c+2; grant stays 0; missed_count increments by 1.
- Reclaim (TDMA_ARB_RECLAIM_EN defined):
  - Stimulus: slot0 owner 0, req = 4'b1010 over two consecutive frames.
  - Required: grant = 4'b0010 in frame 1 and 4'b1000 in frame 2; slot_missed pulses each time.
- Wrap and disable:
  - Stimulus: NUM_SLOTS = 8, 9 slot_start pulses; then enable = 0 while in HOLD.
  - Required: cur_slot sequence 0..7, 0. After enable drops, grant = 0 on the next edge.
  - Required: after re-enable, the first slot_start gives cur_slot = 0.
- Counter saturation and clear:
  - Stimulus: preload via 65535 misses, then one more miss; then cnt_clr asserted in the same cycle as a miss.
  - Required: missed_count = 0xFFFF after the extra miss; 0 after the clear.
- Reset mid-HOLD:
  - Stimulus: ARESETN low for one edge while in HOLD.
  - Required: grant = 0, missed_count = 0, all table entries invalid.
